// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller.
// Access sizes and controller states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle of the data-memory controller.
// master drives requests, slave answers them.
interface dmem_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage, byte-enable write port,
// registered read port.
module dmem_array #(
  parameter  int DEPTH = 256,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // byte-lane masked write
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // synchronous read, sees writes of earlier cycles
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: clear-on-reset FSM, lane steering, load extension.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus,
  output logic  busy
);

  localparam int IW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;

  logic [1:0]    off;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [IW-1:0] idx;
  logic          ready;
  logic          acc;

  logic          arr_we;
  logic [3:0]    arr_be;
  logic [IW-1:0] arr_waddr;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          rsp_ld_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [31:0]   rdata;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          unused_addr;

  assign idx         = bus.req_addr[IW+1:2];
  assign unused_addr = ^bus.req_addr;

  // decode size/offset into lane enables and error
  always_comb begin
    off      = bus.req_addr[1:0];
    err      = (bus.req_size == SZ_RSVD);
    be       = 4'b0000;
    wdata_sh = bus.req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
    if (bus.req_size == SZ_HALF && off[0])
      err = 1'b1;
    if (bus.req_size == SZ_WORD && off != 2'b00)
      err = 1'b1;
`else
    if (bus.req_size == SZ_HALF)
      off[0] = 1'b0;
    if (bus.req_size == SZ_WORD)
      off = 2'b00;
`endif
    unique case (1'b1)
      bus.req_size == SZ_BYTE: begin
        be       = 4'b0001 << off;
        wdata_sh = {4{bus.req_wdata[7:0]}};
      end
      bus.req_size == SZ_HALF: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{bus.req_wdata[15:0]}};
      end
      bus.req_size == SZ_WORD: begin
        be = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
  end

  // FSM next state and array write port muxing
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    ready     = 1'b0;
    arr_we    = 1'b0;
    arr_be    = be;
    arr_waddr = idx;
    arr_wdata = wdata_sh;
    unique case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        arr_we    = 1'b1;
        arr_be    = 4'b1111;
        arr_waddr = clr_cnt_q;
        arr_wdata = '0;
        clr_cnt_d = clr_cnt_q + IW'(1);
        if (clr_cnt_q == IW'(DEPTH - 1))
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        ready  = 1'b1;
        arr_we = bus.req_valid & bus.req_we & ~err;
      end
    endcase
  end

  assign acc           = bus.req_valid & ready;
  assign bus.req_ready = ready;

  // state, clear counter and response pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= acc;
      rsp_err_q   <= acc & err;
      rsp_ld_q    <= acc & ~bus.req_we & ~err;
      uns_q       <= bus.req_unsigned;
      size_q      <= bus.req_size;
      off_q       <= off;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (idx),
    .rdata_o (arr_rdata)
  );

  assign byte_v = 8'(arr_rdata >> {off_q, 3'b000});
  assign half_v = off_q[1] ? arr_rdata[31:16]
                           : arr_rdata[15:0];

  // right-align and extend load data
  always_comb begin
    rdata = '0;
    if (rsp_ld_q) begin
      unique case (1'b1)
        size_q == SZ_BYTE:
          rdata = uns_q ? {24'h0, byte_v}
                        : {{24{byte_v[7]}}, byte_v};
        size_q == SZ_HALF:
          rdata = uns_q ? {16'h0, half_v}
                        : {{16{half_v[15]}}, half_v};
        default:
          rdata = arr_rdata;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl against a byte-array model.
// Define DMEM_ALIGN_CHECK_EN to match a DUT built with alignment checks.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int NB     = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk;
    int          stamp;
    string       tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mdl[NB];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, address taken modulo NB.
  function automatic exp_t model(bit we, logic [1:0] sz, bit uns,
                                 logic [31:0] addr, logic [31:0] wd);
    exp_t        r;
    int          a, n;
    logic [31:0] v;
    r.err   = 1'b0;
    r.data  = '0;
    r.chk   = !we;
    r.stamp = 0;
    r.tag   = "";
    a = int'(addr % NB);
    if (sz == 2'b11) begin
      r.err = 1'b1;
      r.chk = 1'b1;
      return r;
    end
    n = 1 << sz;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % n != 0) begin
      r.err = 1'b1;
      r.chk = 1'b1;
      return r;
    end
`else
    a = a - a % n;
`endif
    if (we) begin
      for (int i = 0; i < n; i++) mdl[a+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(mdl[a+i]) << (8 * i);
      if (n < 4 && !uns && mdl[a+n-1][7])
        v |= ~((32'h1 << (8 * n)) - 32'h1);
      r.data = v;
    end
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) mdl[i] = 8'h00;
  endfunction

  // Monitor: pop and compare whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 required none pending");
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.tag, "_lat"}, 32'(cyc), 32'(mon_e.stamp + 1));
          check({mon_e.tag, "_err"}, 32'(bus.rsp_err), 32'(mon_e.err));
          if (mon_e.chk)
            check({mon_e.tag, "_data"}, bus.rsp_rdata, mon_e.data);
        end
      end else begin
        check("quiet_rdata", bus.rsp_rdata, 32'h0);
        check("quiet_err", 32'(bus.rsp_err), 32'h0);
      end
    end
  end

  task automatic req(bit we, logic [1:0] sz, bit uns,
                     logic [31:0] addr, logic [31:0] wd, string tag);
    exp_t e;
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    e       = model(we, sz, uns, addr, wd);
    e.stamp = cyc;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  // Called at the negedge where rst is released.
  task automatic wait_clear(string tag);
    int n   = 0;
    int bad = 0;
    while (busy && n < 2000) begin
      if (bus.req_ready) bad++;
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 32'(n), 32'(DEPTH));
    check({tag, "_ready_low"}, 32'(bad), 32'h0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish required finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_err", 32'(bus.rsp_err), 32'h0);

    rst = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midclr_busy", 32'(busy), 32'h1);
    check("midclr_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    wait_clear("clear");

    req(0, SZ_WORD, 0, 32'h3FC, 0, "ld3fc");
    req(1, SZ_WORD, 0, 32'h10, 32'h80FF7F01, "st10");
    req(0, SZ_BYTE, 0, 32'h11, 0, "lb11");
    req(0, SZ_BYTE, 0, 32'h12, 0, "lb12");
    req(0, SZ_BYTE, 1, 32'h13, 0, "lbu13");
    req(0, SZ_HALF, 0, 32'h12, 0, "lh12");
    req(0, SZ_HALF, 1, 32'h12, 0, "lhu12");
    req(1, SZ_WORD, 0, 32'h20, 32'h11223344, "st20");
    req(1, SZ_BYTE, 0, 32'h21, 32'h555555AA, "sb21");
    req(0, SZ_WORD, 1, 32'h20, 0, "lw20");
    req(1, SZ_WORD, 0, 32'h0, 32'hCAFEF00D, "st0");
    req(0, SZ_WORD, 0, 32'h402, 0, "lw402");
    req(0, SZ_WORD, 0, 32'h0, 0, "lw0");
    req(1, SZ_WORD, 0, 32'h40, 32'h55667788, "st40");
    req(1, 2'b11, 0, 32'h40, 32'hDEADBEEF, "rsv40");
    req(0, SZ_WORD, 0, 32'h40, 0, "lw40");
    req(1, SZ_HALF, 0, 32'h1003, 32'hABCD9876, "sh_alias");
    req(0, SZ_WORD, 0, 32'h000, 0, "lw_alias");
    idle();
    drain();

    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      ad = 32'($urandom_range(0, 4095));
      req(1'($urandom), sz, 1'($urandom), ad, $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();

    req(0, SZ_WORD, 0, 32'h10, 0, "pend");
    #1;
    rst = 1'b0;
    sb.delete();
    bus.req_valid = 1'b0;
    #1;
    check("drop_valid", 32'(bus.rsp_valid), 32'h0);
    check("drop_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    wait_clear("reclear");
    req(0, SZ_WORD, 0, 32'h10, 0, "lw10_clr");
    req(0, SZ_WORD, 0, 32'h20, 0, "lw20_clr");
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
